spi_xfer_sequencer: RTL
=======================

// Module: spi_xfer_sequencer
// PURPOSE
//   SPI master transfer controller that sequences the byte shift register for one transfer per start request.
//   Drives ss and sclk, the load pulse (send_data), the capture pulse (receive_data) and the four edge strobes
//   (flag_low/flag_high = MISO sample, flags_low/flags_high = MOSI shift).
//   Sits between the APB slave register file and the shift register.
// PARAMETERS
//   DATA_BITS  8   bits per transfer; edge count = 2*DATA_BITS
//   CNT_W      12  width of baud half-period counter
// PORTS
//   PCLK          in   1      system clock, all logic on rising edge
//   PRESET        in   1      synchronous reset, active-high
//   spe           in   1      SPI enable; deassert aborts transfer
//   start         in   1      1-cycle request: data register written, begin transfer
//   cpol          in   1      clock idle level
//   cpha          in   1      0: sample leading edge, 1: sample trailing edge
//   sppr          in   3      baud pre-divider
//   spr           in   3      baud shift
//   spif_clr      in   1      clears spif
//   ss            out  1      slave select, active-low
//   sclk          out  1      SPI clock
//   send_data     out  1      1-cycle load of data_mosi into shift register
//   receive_data  out  1      1-cycle capture of received byte
//   flag_low      out  1      MISO sample strobe, falling edge
//   flag_high     out  1      MISO sample strobe, rising edge
//   flags_low     out  1      MOSI shift strobe, falling edge
//   flags_high    out  1      MOSI shift strobe, rising edge
//   tip           out  1      transfer in progress
//   spif          out  1      sticky transfer-complete flag
// BEHAVIOUR
//   Reset: ss=1, sclk=cpol, all pulses/strobes=0, tip=0, spif=0, state=IDLE.
//   Half-period H = (sppr+1) << spr PCLK cycles (1..1024). cpol/cpha/sppr/spr latched on start; later changes ignored.
//   FSM:
//     IDLE  -> LOAD when start & spe & ~tip (start while busy is ignored). In IDLE, sclk tracks live cpol.
//     LOAD  (1 cycle): send_data=1, ss=0, tip=1 -> SETUP
//     SETUP (H cycles, sclk idle) -> XFER
//     XFER  (2*DATA_BITS edges, H cycles apart) -> HOLD after last edge
//     HOLD  (H cycles, sclk idle) -> DONE
//     DONE  (1 cycle): receive_data=1; spif set next edge -> IDLE, ss=1, tip=0
//   Edge strobe timing: asserted for exactly one cycle, the cycle before sclk toggles (toggle happens at end of strobe cycle).
//   Leading edge = idle->active (rising when cpol=0).
//   Sample edges: leading if cpha=0, trailing if cpha=1. Emit flag_high or flag_low per direction, exactly DATA_BITS strobes.
//   Shift edges: the other edge type. Emit flags_high or flags_low, DATA_BITS-1 strobes:
//     cpha=0: trailing edges 1..7 (8th suppressed); cpha=1: leading edges 2..8 (1st suppressed).
//   Mode map: mode0 flag_high/flags_low; mode1 flag_low/flags_high; mode2 flag_low/flags_high; mode3 flag_high/flags_low.
//   spif: set in cycle after DONE; cleared by spif_clr; set wins over simultaneous clr.
//   Abort: spe=0 in any non-IDLE state -> IDLE next cycle, ss=1, sclk=cpol, no receive_data, spif unchanged.
//   PRESET mid-transfer: same as reset values next cycle.
// CONFIGURATION
//   SPI_BURST_EN defined: start during HOLD or DONE is queued. DONE then goes to LOAD with ss held 0 (no deassert gap).
//     Pending request is cleared by abort.
//   SPI_BURST_EN undefined: start outside IDLE is dropped; ss always returns high for >=1 cycle between bytes.
// STRUCTURE
//   Package spi_ctrl_pkg: state encoding (IDLE, LOAD, SETUP, XFER, HOLD, DONE) and mode-decode constants.
//   Sub-module spi_baud_gen: half-period counter, sclk toggle, edge index, four strobes.
//     Controlled by run/idle_level from the FSM.
// TESTING
//   1 Mode0, sppr=0, spr=0, start -> ss low 20 cycles; 16 sclk edges; 8 flag_high, 7 flags_low, 0 flag_low/flags_high;
//     receive_data 1 pulse; spif=1 after.
//   2 Mode3, sppr=1, spr=1 (H=4) -> sclk idles 1, period 8 PCLK; 8 flag_high, 7 flags_low; each strobe precedes toggle by 1 cycle.
//   3 Mode1 and mode2, H=1 -> 8 flag_low, 7 flags_high; first leading edge has no shift strobe.
//   4 spe=0 at 5th edge -> ss=1, sclk=cpol next cycle; no receive_data; spif stays 0.
//     Repeat with PRESET=1 -> all reset values.
//   5 Second start mid-XFER -> ignored (burst off); with SPI_BURST_EN, start in HOLD -> back-to-back bytes, ss never high.
//   6 spif_clr in same cycle spif sets -> spif=1; spif_clr next cycle -> spif=0.

Source files
------------

// File: rtl/spi_ctrl_pkg.sv
// Shared types for the SPI transfer sequencer: FSM state encoding, latched
// transfer configuration and clock-phase decode helpers.
package spi_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SETUP,
    XFER,
    HOLD,
    DONE
  } state_t;

  typedef struct packed {
    logic       cpol;
    logic       cpha;
    logic [2:0] sppr;
    logic [2:0] spr;
  } xfer_cfg_t;

  localparam logic CPHA_SAMPLE_LEADING  = 1'b0;
  localparam logic CPHA_SAMPLE_TRAILING = 1'b1;

  // Even edge indices are leading edges, so the sample edges are the ones whose parity equals cpha
  function automatic logic is_sample_edge(input logic cpha, input logic edge_odd);
    return edge_odd == cpha;
  endfunction

endpackage

// File: rtl/spi_baud_gen.sv
// Half-period counter and SPI clock generator: paces SETUP/XFER/HOLD, toggles
// sclk during XFER and raises the MISO-sample / MOSI-shift strobes one cycle before each toggle.
module spi_baud_gen
  import spi_ctrl_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int CNT_W     = 12
) (
  input  logic             PCLK,
  input  logic             PRESET,
  input  logic             count_en,
  input  logic             run,
  input  logic             idle_level,
  input  logic             cpha,
  input  logic [CNT_W-1:0] half,
  output logic             tick,
  output logic             last_edge,
  output logic             sclk,
  output logic             flag_low,
  output logic             flag_high,
  output logic             flags_low,
  output logic             flags_high
);

  localparam int EDGES  = 2 * DATA_BITS;
  localparam int EDGE_W = $clog2(EDGES);

  logic [CNT_W-1:0]  cnt;
  logic [EDGE_W-1:0] edge_idx;
  logic              sclk_q;
  logic              edge_fire;
  logic              sample_edge;
  logic              shift_edge;
  logic              suppressed;

  assign tick      = count_en && (cnt == half - CNT_W'(1));
  assign last_edge = edge_idx == EDGE_W'(EDGES - 1);

  always_ff @(posedge PCLK) begin
    if (PRESET || !count_en || tick) cnt <= '0;
    else                             cnt <= cnt + CNT_W'(1);
  end

  always_ff @(posedge PCLK) begin
    if (PRESET || !run) edge_idx <= '0;
    else if (tick)      edge_idx <= edge_idx + EDGE_W'(1);
  end

  // Outside XFER the register follows the idle level so the first toggle always starts from idle
  always_ff @(posedge PCLK) begin
    if (PRESET)    sclk_q <= 1'b0;
    else if (!run) sclk_q <= idle_level;
    else if (tick) sclk_q <= ~sclk_q;
  end

  assign sclk = run ? sclk_q : idle_level;

  // The one shift edge with no data to move: the last trailing edge (cpha=0) or the first leading edge (cpha=1)
  assign suppressed  = (cpha == CPHA_SAMPLE_LEADING) ? last_edge : (edge_idx == '0);
  assign edge_fire   = run && tick;
  assign sample_edge = is_sample_edge(cpha, edge_idx[0]);
  assign shift_edge  = !sample_edge && !suppressed;

  assign flag_high  = edge_fire && sample_edge && !sclk_q;
  assign flag_low   = edge_fire && sample_edge &&  sclk_q;
  assign flags_high = edge_fire && shift_edge  && !sclk_q;
  assign flags_low  = edge_fire && shift_edge  &&  sclk_q;

endmodule

// File: rtl/spi_xfer_sequencer.sv
// SPI master transfer sequencer: one byte transfer per start request, driving ss, sclk and the shift-register strobes.
// Define SPI_BURST_EN to queue a start seen in HOLD/DONE and chain bytes without releasing ss.
module spi_xfer_sequencer
  import spi_ctrl_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int CNT_W     = 12
) (
  input  logic       PCLK,
  input  logic       PRESET,
  input  logic       spe,
  input  logic       start,
  input  logic       cpol,
  input  logic       cpha,
  input  logic [2:0] sppr,
  input  logic [2:0] spr,
  input  logic       spif_clr,
  output logic       ss,
  output logic       sclk,
  output logic       send_data,
  output logic       receive_data,
  output logic       flag_low,
  output logic       flag_high,
  output logic       flags_low,
  output logic       flags_high,
  output logic       tip,
  output logic       spif
);

  state_t     state, next_state;
  xfer_cfg_t  cfg, live_cfg, launch_cfg;
  logic       go, abort, launch;
  logic       tick, last_edge;
  logic [3:0] div;
  logic [CNT_W-1:0] half;

  assign live_cfg = '{cpol: cpol, cpha: cpha, sppr: sppr, spr: spr};
  assign go       = (state == IDLE) && start && spe;
  assign abort    = (state != IDLE) && !spe;

`ifdef SPI_BURST_EN
  logic      pend_q;
  xfer_cfg_t pend_cfg;

  assign launch     = (state == DONE) && spe && (pend_q || start);
  assign launch_cfg = pend_q ? pend_cfg : live_cfg;

  // A queued request keeps its own settings so the byte still in flight is undisturbed
  always_ff @(posedge PCLK) begin
    if (PRESET || abort || launch) begin
      pend_q <= 1'b0;
    end else if ((state == HOLD || state == DONE) && start && spe) begin
      pend_q   <= 1'b1;
      pend_cfg <= live_cfg;
    end
  end
`else
  assign launch     = 1'b0;
  assign launch_cfg = live_cfg;
`endif

  always_ff @(posedge PCLK) begin
    if (PRESET)      cfg <= '0;
    else if (go)     cfg <= live_cfg;
    else if (launch) cfg <= launch_cfg;
  end

  assign div  = {1'b0, cfg.sppr} + 4'd1;
  assign half = CNT_W'(div) << cfg.spr;

  always_ff @(posedge PCLK) begin
    if (PRESET) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (go) next_state = LOAD;
      LOAD:    next_state = SETUP;
      SETUP:   if (tick) next_state = XFER;
      XFER:    if (tick && last_edge) next_state = HOLD;
      HOLD:    if (tick) next_state = DONE;
      DONE:    next_state = launch ? LOAD : IDLE;
      default: next_state = IDLE;
    endcase
    if (abort) next_state = IDLE;
  end

  // receive_data is gated by spe so an abort landing on DONE never captures a byte
  always_comb begin
    ss           = 1'b1;
    tip          = 1'b0;
    send_data    = 1'b0;
    receive_data = 1'b0;
    if (state != IDLE) begin
      ss  = 1'b0;
      tip = 1'b1;
    end
    if (state == LOAD) send_data = 1'b1;
    if (state == DONE) receive_data = spe;
  end

  always_ff @(posedge PCLK) begin
    if (PRESET)                     spif <= 1'b0;
    else if (state == DONE && spe)  spif <= 1'b1;
    else if (spif_clr)              spif <= 1'b0;
  end

  spi_baud_gen #(
    .DATA_BITS(DATA_BITS),
    .CNT_W    (CNT_W)
  ) u_baud (
    .PCLK      (PCLK),
    .PRESET    (PRESET),
    .count_en  (state == SETUP || state == XFER || state == HOLD),
    .run       (state == XFER),
    .idle_level((state == IDLE) ? cpol : cfg.cpol),
    .cpha      (cfg.cpha),
    .half      (half),
    .tick      (tick),
    .last_edge (last_edge),
    .sclk      (sclk),
    .flag_low  (flag_low),
    .flag_high (flag_high),
    .flags_low (flags_low),
    .flags_high(flags_high)
  );

endmodule
